decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/decode_imm_gen.sv | 23 ++
 rtl/decode.sv | 183 ++++++++++++++++++
 tb/tb_decode.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, kind/alu_op enumerations,
// SYSTEM encodings, CSR funct3 values, immediate formats and the registered decode bundle.
package decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
   localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
   localparam logic [31:0] SYS_MRET   = 32'h3020_0073;

   localparam logic [2:0] F3_CSRRW  = 3'd1;
   localparam logic [2:0] F3_CSRRS  = 3'd2;
   localparam logic [2:0] F3_CSRRC  = 3'd3;
   localparam logic [2:0] F3_CSRRWI = 3'd5;
   localparam logic [2:0] F3_CSRRSI = 3'd6;
   localparam logic [2:0] F3_CSRRCI = 3'd7;

   typedef enum logic [3:0] {
      K_NOP, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BRANCH,
      K_LOAD, K_STORE, K_OPIMM, K_OP, K_SYSTEM, K_CSR
   } kind_e;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
   } alu_op_e;

   typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   typedef struct packed {
      kind_e      kind;
      alu_op_e    alu_op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       reg_we;
      logic       is_ecall;
      logic       is_ebreak;
      logic       is_mret;
      logic       illegal;
   } dec_t;

   // alt selects SUB/SRA; callers gate it so ADDI never becomes a subtract
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate builder; all formats sign-extend from bit 31.
module imm_gen
   import decode_pkg::*;
(
   input  logic [31:0] word,
   input  fmt_e        fmt,
   output logic [31:0] imm
);
   logic unused_opc;
   assign unused_opc = ^word[6:0];

   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:   imm = {{20{word[31]}}, word[31:20]};
         FMT_S:   imm = {{20{word[31]}}, word[31:25], word[11:7]};
         FMT_B:   imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
         FMT_U:   imm = {word[31:12], 12'b0};
         FMT_J:   imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
         default: imm = '0;
      endcase
   end
endmodule

// File: rtl/decode.sv
// RV32I decode stage: capture on enabled, decode in BUSY, hold bundle in DONE.
// CSR instructions are decoded only when DECODE_CSR_EN is defined.
module decode
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        enabled,
   input  logic [31:0] pc,
   input  logic [31:0] instr_raw,
   output logic        completed,
   output logic [31:0] pc_n,
   output logic [3:0]  kind,
   output logic [4:0]  alu_op,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm,
   output logic [11:0] csr_addr,
   output logic        reg_we,
   output logic        is_ecall,
   output logic        is_ebreak,
   output logic        is_mret,
   output logic        illegal
);
   state_e      state, state_n;
   logic [31:0] instr_q, pc_q, imm_w, imm_q;
   dec_t        d, q;
   fmt_e        fmt;
   logic        bad, use_rd, use_rs1, use_rs2;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
`ifdef DECODE_CSR_EN
   logic [11:0] csr_n, csr_q;
`endif

   assign opc = instr_q[6:0];
   assign f3  = instr_q[14:12];
   assign f7  = instr_q[31:25];

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= S_IDLE;
      else       state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE: if (enabled) state_n = S_BUSY;
         S_BUSY:         state_n = S_DONE;
         default:        state_n = S_IDLE;
      endcase
   end

   assign completed = (state == S_DONE) & ~enabled;

   always_comb begin
      d = '0;
      fmt = FMT_NONE;
      bad = 1'b0;
      use_rd = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
`ifdef DECODE_CSR_EN
      csr_n = '0;
`endif
      case (opc)
         OPC_LUI:   begin d.kind = K_LUI;   fmt = FMT_U; use_rd = 1'b1; end
         OPC_AUIPC: begin d.kind = K_AUIPC; fmt = FMT_U; use_rd = 1'b1; end
         OPC_JAL:   begin d.kind = K_JAL;   fmt = FMT_J; use_rd = 1'b1; end
         OPC_JALR: begin
            d.kind = K_JALR; fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            bad = (f3 != 3'd0);
         end
         OPC_BRANCH: begin
            d.kind = K_BRANCH; fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
            bad = (f3[2:1] == 2'b01);
            case (f3)
               3'd0:    d.alu_op = ALU_EQ;
               3'd1:    d.alu_op = ALU_NE;
               3'd4:    d.alu_op = ALU_LT;
               3'd5:    d.alu_op = ALU_GE;
               3'd6:    d.alu_op = ALU_LTU;
               default: d.alu_op = ALU_GEU;
            endcase
         end
         OPC_LOAD: begin
            d.kind = K_LOAD; fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_STORE: begin
            d.kind = K_STORE; fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            bad = (f3 > 3'd2);
         end
         OPC_OPIMM: begin
            d.kind = K_OPIMM; fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
            d.alu_op = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
            // shift-immediates carry funct7 in the upper immediate bits
            bad = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                  ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
         end
         OPC_OP: begin
            d.kind = K_OP; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            d.alu_op = alu_from_f3(f3, f7[5]);
            bad = (f7 != 7'h00) && (f7 != 7'h20);
         end
         OPC_SYSTEM: begin
            if (f3 == 3'd0) begin
               d.kind      = K_SYSTEM;
               d.is_ecall  = (instr_q == SYS_ECALL);
               d.is_ebreak = (instr_q == SYS_EBREAK);
               d.is_mret   = (instr_q == SYS_MRET);
               bad = !(d.is_ecall || d.is_ebreak || d.is_mret);
            end else if (f3 == 3'd4) begin
               bad = 1'b1;
            end else begin
`ifdef DECODE_CSR_EN
               // for the immediate forms the rs1 field is the zimm
               d.kind = K_CSR; use_rd = 1'b1; use_rs1 = 1'b1;
               csr_n = instr_q[31:20];
`else
               bad = 1'b1;
`endif
            end
         end
         default: bad = (instr_q != 32'd0);
      endcase
      d.rd     = use_rd  ? instr_q[11:7]  : 5'd0;
      d.rs1    = use_rs1 ? instr_q[19:15] : 5'd0;
      d.rs2    = use_rs2 ? instr_q[24:20] : 5'd0;
      d.reg_we = use_rd && (instr_q[11:7] != 5'd0);
      if (bad) begin
         d = '0;
         d.illegal = 1'b1;
         fmt = FMT_NONE;
`ifdef DECODE_CSR_EN
         csr_n = '0;
`endif
      end
   end

   imm_gen u_imm_gen (.word(instr_q), .fmt(fmt), .imm(imm_w));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         instr_q <= '0;
         pc_q    <= '0;
         q       <= '0;
         imm_q   <= '0;
         pc_n    <= '0;
      end else begin
         if (state != S_BUSY && enabled) begin
            instr_q <= instr_raw;
            pc_q    <= pc;
         end
         if (state == S_BUSY) begin
            q     <= d;
            imm_q <= imm_w;
            pc_n  <= pc_q;
         end
      end
   end

`ifdef DECODE_CSR_EN
   always_ff @(posedge clk or negedge rstn)
      if (!rstn)                csr_q <= '0;
      else if (state == S_BUSY) csr_q <= csr_n;
   assign csr_addr = csr_q;
`else
   assign csr_addr = '0;
`endif

   assign kind      = q.kind;
   assign alu_op    = q.alu_op;
   assign rd        = q.rd;
   assign rs1       = q.rs1;
   assign rs2       = q.rs2;
   assign imm       = imm_q;
   assign reg_we    = q.reg_we;
   assign is_ecall  = q.is_ecall;
   assign is_ebreak = q.is_ebreak;
   assign is_mret   = q.is_mret;
   assign illegal   = q.illegal;
endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: stimulus pushes hand-computed bundles, a negedge monitor
// pops one entry on each rising completed and compares every output field.
module tb_decode;
   import decode_pkg::*;

   logic        clk = 1'b0, rstn = 1'b1, enabled = 1'b0;
   logic [31:0] pc = '0, instr_raw = '0;
   logic        completed, reg_we, is_ecall, is_ebreak, is_mret, illegal;
   logic [31:0] pc_n, imm;
   logic [3:0]  kind;
   logic [4:0]  alu_op, rd, rs1, rs2;
   logic [11:0] csr_addr;

   decode dut (
      .clk(clk), .rstn(rstn), .enabled(enabled), .pc(pc), .instr_raw(instr_raw),
      .completed(completed), .pc_n(pc_n), .kind(kind), .alu_op(alu_op),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .csr_addr(csr_addr), .reg_we(reg_we),
      .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      kind_e       kind;
      alu_op_e     alu;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic [11:0] csr;
      logic        we;
      logic [3:0]  flg;   // {ecall, ebreak, mret, illegal}
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0, failures = 0;
   logic prev_c = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] p, input kind_e k, input alu_op_e a,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] im, input logic [11:0] ca, input logic we,
                               input logic [3:0] fl);
      exp_t e;
      e.pc = p; e.kind = k; e.alu = a; e.rd = d; e.rs1 = s1; e.rs2 = s2;
      e.imm = im; e.csr = ca; e.we = we; e.flg = fl;
      return e;
   endfunction

   always @(negedge clk) begin
      if (completed && !prev_c) begin
         if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_completion actual=pc_n %h expected=no completion", pc_n);
         end else begin
            mon_e = sbq.pop_front();
            chk("pc_n", pc_n, mon_e.pc);
            chk("kind", 32'(kind), 32'(mon_e.kind));
            chk("alu_op", 32'(alu_op), 32'(mon_e.alu));
            chk("rd", 32'(rd), 32'(mon_e.rd));
            chk("rs1", 32'(rs1), 32'(mon_e.rs1));
            chk("rs2", 32'(rs2), 32'(mon_e.rs2));
            chk("imm", imm, mon_e.imm);
            chk("csr_addr", 32'(csr_addr), 32'(mon_e.csr));
            chk("reg_we", 32'(reg_we), 32'(mon_e.we));
            chk("flags", 32'({is_ecall, is_ebreak, is_mret, illegal}), 32'(mon_e.flg));
            chk("flags_onehot", 32'($countones({is_ecall, is_ebreak, is_mret, illegal}) <= 1), 1);
         end
      end
      prev_c = completed;
   end

   task automatic send(input logic [31:0] w, input logic [31:0] p, input exp_t e);
      @(posedge clk); #1;
      enabled = 1'b1; instr_raw = w; pc = p;
      sbq.push_back(e);
      #1 chk("completed_while_enabled", 32'(completed), 0);
      @(posedge clk); #1;
      enabled = 1'b0; instr_raw = $urandom; pc = $urandom;
      chk("completed_busy", 32'(completed), 0);
      @(posedge clk); #1;
      chk("completed_done", 32'(completed), 1);
      @(negedge clk); #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_pc_n"}, pc_n, 0);
      chk({nm, "_imm"}, imm, 0);
      chk({nm, "_csr"}, 32'(csr_addr), 0);
      chk({nm, "_fields"}, 32'({kind, alu_op, rd, rs1, rs2, reg_we,
                                is_ecall, is_ebreak, is_mret, illegal, completed}), 0);
   endtask

   initial begin
      #2 rstn = 1'b0;
      #2 chk_zero("reset");
      @(posedge clk); #1 rstn = 1'b1;

      send(32'hFE010113, 32'd1,     mk(32'd1,     K_OPIMM,  ALU_ADD, 2, 2, 0, 32'hFFFFFFE0, 0, 1, 4'b0000));
      send(32'h08C000EF, 32'h100,   mk(32'h100,   K_JAL,    ALU_ADD, 1, 0, 0, 32'h0000008C, 0, 1, 4'b0000));
      send(32'h00E7C663, 32'h104,   mk(32'h104,   K_BRANCH, ALU_LT,  0, 15, 14, 32'd12,     0, 0, 4'b0000));
      send(32'h00100073, 32'h108,   mk(32'h108,   K_SYSTEM, ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0100));
      send(32'h00000073, 32'h10C,   mk(32'h10C,   K_SYSTEM, ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b1000));
      send(32'h30200073, 32'h110,   mk(32'h110,   K_SYSTEM, ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0010));
      send(32'h00000000, 32'h114,   mk(32'h114,   K_NOP,    ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0000));
`ifdef DECODE_CSR_EN
      send(32'h34202673, 32'h118,   mk(32'h118,   K_CSR,    ALU_ADD, 12, 0, 0, 0, 12'h342, 1, 4'b0000));
`else
      send(32'h34202673, 32'h118,   mk(32'h118,   K_NOP,    ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0001));
`endif
      send(32'h123452B7, 32'h11C,   mk(32'h11C,   K_LUI,    ALU_ADD, 5, 0, 0, 32'h12345000, 0, 1, 4'b0000));
      send(32'hFE112E23, 32'h120,   mk(32'h120,   K_STORE,  ALU_ADD, 0, 2, 1, 32'hFFFFFFFC, 0, 0, 4'b0000));
      send(32'h02208033, 32'h124,   mk(32'h124,   K_NOP,    ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0001));
      send(32'h0000007F, 32'h128,   mk(32'h128,   K_NOP,    ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0001));
      send(32'h00002063, 32'h12C,   mk(32'h12C,   K_NOP,    ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0001));
      send(32'h10500073, 32'h130,   mk(32'h130,   K_NOP,    ALU_ADD, 0, 0, 0, 0, 0, 0, 4'b0001));
      send(32'h00100013, 32'h134,   mk(32'h134,   K_OPIMM,  ALU_ADD, 0, 0, 0, 32'd1, 0, 0, 4'b0000));

      // second word offered during BUSY must be dropped
      @(posedge clk); #1;
      enabled = 1'b1; instr_raw = 32'h40B50533; pc = 32'h200;
      sbq.push_back(mk(32'h200, K_OP, ALU_SUB, 10, 10, 11, 0, 0, 1, 4'b0000));
      @(posedge clk); #1;
      instr_raw = 32'h123452B7; pc = 32'h204;
      @(posedge clk); #1;
      enabled = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("hold_rd", 32'(rd), 10);
      chk("hold_pc_n", pc_n, 32'h200);
      chk("hold_completed", 32'(completed), 1);

      // reset while BUSY clears everything at once
      @(posedge clk); #1;
      enabled = 1'b1; instr_raw = 32'h123452B7; pc = 32'h300;
      @(posedge clk); #1;
      enabled = 1'b0;
      #1 rstn = 1'b0;
      #1 chk_zero("midbusy_reset");
      @(posedge clk); #1 rstn = 1'b1;
      send(32'h08C000EF, 32'h400,   mk(32'h400,   K_JAL,    ALU_ADD, 1, 0, 0, 32'h0000008C, 0, 1, 4'b0000));

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
